spi_accel_slave: RTL and testbench
==================================

Name: spi_accel_slave

Overview:
- SPI responder for the accelerometer register protocol that the SPI master block drives. It decodes the 16-bit write frame and the multi-byte read frame, and holds a 64 x 8 register file.
- The register file is fed with sample data from the fabric side.
- Used as the sensor model in system simulation, and as the on-board responder when the master links two boards.
- Mode 3 operation:
  - SCLK idles high.
  - MOSI is sampled on SCLK rise.
  - MISO is advanced immediately after each rise.

Parameters:
- DEVID, 8'hE5, read-only contents of address 0x00.
- SAMPLE_BASE, 6'h32, first of 6 consecutive addresses loaded by sample_we.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset (asserted when 0)
- SCLK  in  1  SPI clock from master, idles high, asynchronous to clk
- CS  in  1  chip select, active low, asynchronous
- MOSI  in  1  serial data from master, asynchronous
- MISO  out  1  serial data to master
- sample_we  in  1  load sample_data into registers SAMPLE_BASE..SAMPLE_BASE+5
- sample_data  in  48  byte k = bits [8k+7:8k] goes to SAMPLE_BASE+k
- wr_valid  out  1  one-clk pulse when an SPI write commits
- wr_addr  out  6  address of the committed write
- wr_data  out  8  data of the committed write
- busy  out  1  synchronized CS is low

Behaviour:
- Reset (reset==0 at posedge clk):
  - MISO, wr_valid, busy = 0; wr_addr = 0, wr_data = 0.
  - All registers = 0; pending sample cleared; FSM = IDLE.
  - Reset mid-transaction aborts it; the FSM re-enters IDLE and waits for a fresh CS fall.
- Input synchronization:
  - SCLK, CS and MOSI each pass through 2 flops; the design uses the synced copies only.
  - rise = synced SCLK 0->1; both SCLK edges are detected against the previous synced value.
  - Timing requirement: SCLK high and low phases each >= 2 clk; CS setup/hold to the first/last edge >= 2 clk. The master's 4-clk SCLK period is supported.
- Frame format, MSB first:
  - Command byte: {RW, MB, A[5:0]}.
  - Then N data bytes, N >= 0, until CS rises.
- FSM states IDLE, CMD, WDATA, RDATA:
  - IDLE: synced CS falls -> CMD, bit counter = 0, busy = 1.
  - CMD: each rise shifts MOSI into the command register. On the 8th rise, latch RW/MB/A and go to RDATA if RW=1, else WDATA.
  - WDATA: each rise shifts MOSI in. On the 8th rise of a byte:
    - write reg[A] (address 0x00 is ignored);
    - set wr_valid = 1 for exactly 1 clk, with wr_addr = A and wr_data = the byte, even for A=0x00;
    - advance A.
  - RDATA, byte load: on the 8th rise of the command or of a previous data byte, load the shift register from reg[A] (DEVID when A=0x00) and advance A. MISO = bit 7 in the next clk.
  - RDATA, bit shift: each subsequent rise shifts MISO to the next lower bit.
  - Any state: synced CS rises -> IDLE, busy = 0, MISO = 0. A partial command or data byte is discarded with no write and no wr_valid.
- Address advance:
  - MB=1: A = A+1, wrapping 0x3F -> 0x00.
  - MB=0: A is held, so repeated bytes target the same register.
- MISO = 0 in IDLE, CMD and WDATA.
- Sample loading:
  - sample_we while busy = 0 writes the 6 bytes in that clk.
  - sample_we while busy = 1 captures sample_data into a pending buffer; the latest request wins. The buffer is applied in the clk busy returns to 0, so a read burst never tears.
  - If an SPI write commits in the same clk as a sample write to the same address, the SPI write wins for that byte.
- Latency: wr_valid asserts 3 clk after the physical 8th SCLK rise (2 sync + 1 register).

Test Plan:
- Write frame: cmd 0x2D, data 0x08 -> one wr_valid pulse with wr_addr = 0x2D and wr_data = 0x08. Then read cmd 0xAD -> MISO byte 0x08.
- Read cmd 0x80, one byte -> MISO returns 0xE5 (DEVID). Write 0x00 = 0x55 -> wr_valid pulses, and a subsequent read still returns 0xE5.
- sample_we with 48'h0123456789AB while idle, then burst read cmd 0xF2 (RW=1, MB=1, A=0x32), 6 bytes -> AB, 89, 67, 45, 23, 01.
- Same burst with sample_we = 48'hFFFFFFFFFFFF pulsed after byte 2 -> all 6 bytes read old values. A second burst reads FF x6.
- Burst read from 0x3F with MB=1, 2 bytes -> reg[0x3F], then 0xE5 (wrap to 0x00).
- Abort cases:
  - CS raised after 5 bits of a write data byte -> no wr_valid and the register is unchanged.
  - reset = 0 mid-read -> MISO = 0 and busy = 0 next clk; the next full frame decodes correctly.

Source files
------------

// File: rtl/spi_accel_slave.sv
// SPI mode-3 responder for the accelerometer register protocol: 64 x 8 register file,
// write/read frame decode with optional auto-increment, and fabric-side sample loading.
`timescale 1ns/1ps
module spi_accel_slave #(
  parameter logic [7:0] DEVID       = 8'hE5,
  parameter logic [5:0] SAMPLE_BASE = 6'h32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        SCLK,
  input  logic        CS,
  input  logic        MOSI,
  output logic        MISO,
  input  logic        sample_we,
  input  logic [47:0] sample_data,
  output logic        wr_valid,
  output logic [5:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CMD   = 2'd1;
  localparam logic [1:0] ST_WDATA = 2'd2;
  localparam logic [1:0] ST_RDATA = 2'd3;

  logic        sclk_meta_q, sclk_sync_q, sclk_prev_q;
  logic        cs_meta_q, cs_sync_q, cs_prev_q;
  logic        mosi_meta_q, mosi_sync_q;

  logic [1:0]  state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  tx_q, tx_d;
  logic [5:0]  addr_q, addr_d;
  logic        mb_q, mb_d;
  logic        miso_q, miso_d;
  logic        wr_valid_q, wr_valid_d;
  logic [5:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        busy_q;
  logic        pend_q, pend_d;
  logic [47:0] pend_data_q, pend_data_d;
  logic [7:0]  regs_q [64];
  logic [7:0]  regs_d [64];

  logic        sclk_rise, cs_fall, byte_done, spi_we;
  logic [7:0]  rx_byte, rd_byte;
  logic [5:0]  rd_addr, addr_next;

  // The CS chain resets low so a CS already held low across reset is not seen as a
  // fresh fall; a new frame needs CS to go high and then low again.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sclk_meta_q <= 1'b1;
      sclk_sync_q <= 1'b1;
      sclk_prev_q <= 1'b1;
      cs_meta_q   <= 1'b0;
      cs_sync_q   <= 1'b0;
      cs_prev_q   <= 1'b0;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
    end else begin
      sclk_meta_q <= SCLK;
      sclk_sync_q <= sclk_meta_q;
      sclk_prev_q <= sclk_sync_q;
      cs_meta_q   <= CS;
      cs_sync_q   <= cs_meta_q;
      cs_prev_q   <= cs_sync_q;
      mosi_meta_q <= MOSI;
      mosi_sync_q <= mosi_meta_q;
    end
  end

  assign sclk_rise = sclk_sync_q & ~sclk_prev_q;
  assign cs_fall   = cs_prev_q & ~cs_sync_q;
  assign rx_byte   = {shift_q[6:0], mosi_sync_q};
  assign byte_done = sclk_rise && (bit_cnt_q == 3'd7);
  assign addr_next = mb_q ? addr_q + 6'd1 : addr_q;
  assign rd_addr   = (state_q == ST_CMD) ? rx_byte[5:0] : addr_q;
  assign rd_byte   = (rd_addr == 6'd0) ? DEVID : regs_q[rd_addr];

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    addr_d     = addr_q;
    mb_d       = mb_q;
    miso_d     = miso_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    spi_we     = 1'b0;
    if (state_q == ST_IDLE) begin
      miso_d = 1'b0;
      if (cs_fall) begin
        state_d   = ST_CMD;
        bit_cnt_d = 3'd0;
      end
    end else if (cs_sync_q) begin
      state_d   = ST_IDLE;
      miso_d    = 1'b0;
      bit_cnt_d = 3'd0;
    end else if (sclk_rise) begin
      shift_d   = rx_byte;
      bit_cnt_d = bit_cnt_q + 3'd1;
      case (state_q)
        ST_CMD: begin
          if (byte_done) begin
            mb_d = rx_byte[6];
            if (rx_byte[7]) begin
              state_d = ST_RDATA;
              tx_d    = rd_byte;
              miso_d  = rd_byte[7];
              addr_d  = rx_byte[6] ? rx_byte[5:0] + 6'd1 : rx_byte[5:0];
            end else begin
              state_d = ST_WDATA;
              addr_d  = rx_byte[5:0];
            end
          end
        end
        ST_WDATA: begin
          if (byte_done) begin
            spi_we     = (addr_q != 6'd0);
            wr_valid_d = 1'b1;
            wr_addr_d  = addr_q;
            wr_data_d  = rx_byte;
            addr_d     = addr_next;
          end
        end
        default: begin
          if (byte_done) begin
            tx_d   = rd_byte;
            miso_d = rd_byte[7];
            addr_d = addr_next;
          end else begin
            tx_d   = {tx_q[6:0], 1'b0};
            miso_d = tx_q[6];
          end
        end
      endcase
    end
  end

  // Samples arriving mid-frame are parked and applied once the frame ends, so a
  // burst read always sees one coherent sample set. SPI writes take priority.
  always_comb begin
    regs_d      = regs_q;
    pend_d      = pend_q & busy_q;
    pend_data_d = pend_data_q;
    if (!busy_q && pend_q) begin
      for (int k = 0; k < 6; k++) regs_d[SAMPLE_BASE + 6'(k)] = pend_data_q[8*k +: 8];
    end
    if (sample_we) begin
      if (busy_q) begin
        pend_d      = 1'b1;
        pend_data_d = sample_data;
      end else begin
        for (int k = 0; k < 6; k++) regs_d[SAMPLE_BASE + 6'(k)] = sample_data[8*k +: 8];
      end
    end
    if (spi_we) regs_d[addr_q] = rx_byte;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      tx_q        <= 8'h00;
      addr_q      <= 6'd0;
      mb_q        <= 1'b0;
      miso_q      <= 1'b0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= 6'd0;
      wr_data_q   <= 8'h00;
      busy_q      <= 1'b0;
      pend_q      <= 1'b0;
      pend_data_q <= 48'h0;
      for (int i = 0; i < 64; i++) regs_q[i] <= 8'h00;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      addr_q      <= addr_d;
      mb_q        <= mb_d;
      miso_q      <= miso_d;
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= (state_d != ST_IDLE);
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      regs_q      <= regs_d;
    end
  end

  assign MISO     = miso_q;
  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_spi_accel_slave.sv
// Directed bench for spi_accel_slave: frame-level register model, write-event
// scoreboard, per-cycle idle-MISO check and literal expectations from the test plan.
`timescale 1ns/1ps
module tb_spi_accel_slave;

  localparam int HALF = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        SCLK = 1'b1;
  logic        CS = 1'b1;
  logic        MOSI = 1'b0;
  logic        sample_we = 1'b0;
  logic [47:0] sample_data = 48'h0;
  logic        MISO;
  logic        wr_valid;
  logic [5:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        busy;

  int          checks = 0;
  int          errors = 0;
  logic [13:0] exp_q[$];
  logic [13:0] exp_e;
  logic [7:0]  model_regs [64];
  logic        model_pend;
  logic [47:0] model_pend_data;
  logic        miso_quiet = 1'b0;
  logic [7:0]  tx_buf [16];
  logic [7:0]  rx_buf [16];
  logic [7:0]  lit [6];
  logic [7:0]  r;

  spi_accel_slave dut (
    .clk(clk), .reset(reset), .SCLK(SCLK), .CS(CS), .MOSI(MOSI), .MISO(MISO),
    .sample_we(sample_we), .sample_data(sample_data), .wr_valid(wr_valid),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] model_read(input logic [5:0] a);
    return (a == 6'd0) ? 8'hE5 : model_regs[a];
  endfunction

  task automatic model_load(input logic [47:0] d);
    for (int k = 0; k < 6; k++) model_regs[6'h32 + 6'(k)] = d[8*k +: 8];
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) model_regs[i] = 8'h00;
    model_pend = 1'b0;
    model_pend_data = 48'h0;
    exp_q.delete();
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nb, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nb; i--) begin
      SCLK = 1'b0;
      MOSI = tx[i];
      wait_clk(HALF);
      rx[i] = MISO;
      SCLK = 1'b1;
      wait_clk(HALF);
    end
  endtask

  task automatic sample_idle(input logic [47:0] d);
    sample_we = 1'b1;
    sample_data = d;
    wait_clk(1);
    sample_we = 1'b0;
    model_load(d);
  endtask

  // tx_buf[0] is the command, tx_buf[1..nbytes-1] data; extra_bits of tx_buf[nbytes]
  // form a truncated trailing byte. pulse_after >= 0 fires sample_we after that byte.
  task automatic spi_frame(input int nbytes, input int extra_bits, input int pulse_after,
                           input logic [47:0] pulse_data);
    logic       rw, mb;
    logic [5:0] a;
    logic [7:0] exp_rd [16];
    logic [7:0] rb;
    rw = tx_buf[0][7];
    mb = tx_buf[0][6];
    a  = tx_buf[0][5:0];
    for (int i = 1; i < nbytes; i++) begin
      if (rw) exp_rd[i] = model_read(a);
      else begin
        exp_q.push_back({a, tx_buf[i]});
        if (a != 6'd0) model_regs[a] = tx_buf[i];
      end
      if (mb) a = a + 6'd1;
    end
    if (rw) miso_quiet = 1'b0;
    CS = 1'b0;
    wait_clk(4);
    check8("busy_in_frame", {7'd0, busy}, 8'd1);
    for (int i = 0; i < nbytes; i++) begin
      spi_bits(tx_buf[i], 8, rb);
      rx_buf[i] = rb;
      if (i == pulse_after) begin
        sample_we = 1'b1;
        sample_data = pulse_data;
        wait_clk(1);
        sample_we = 1'b0;
        model_pend = 1'b1;
        model_pend_data = pulse_data;
      end
    end
    if (extra_bits > 0) spi_bits(tx_buf[nbytes], extra_bits, rb);
    wait_clk(4);
    CS = 1'b1;
    wait_clk(8);
    check8("busy_after_frame", {7'd0, busy}, 8'd0);
    if (model_pend) begin
      model_load(model_pend_data);
      model_pend = 1'b0;
    end
    if (rw) begin
      for (int i = 1; i < nbytes; i++)
        check8($sformatf("read_byte%0d_cmd%02h", i, tx_buf[0]), rx_buf[i], exp_rd[i]);
    end
    miso_quiet = 1'b1;
  endtask

  // Continuous compare: every wr_valid must match the next expected write, and MISO
  // must stay low whenever no read frame is in progress.
  always @(negedge clk) begin
    if (reset) begin
      if (wr_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL wr_unexpected: got addr %02h data %02h expected no write", wr_addr, wr_data);
        end else begin
          exp_e = exp_q.pop_front();
          if ({wr_addr, wr_data} !== exp_e) begin
            errors++;
            $display("FAIL wr_event: got addr %02h data %02h expected addr %02h data %02h",
                     wr_addr, wr_data, exp_e[13:8], exp_e[7:0]);
          end
        end
      end
      if (miso_quiet) begin
        checks++;
        if (MISO !== 1'b0) begin
          errors++;
          $display("FAIL miso_idle: got %b expected 0", MISO);
        end
      end
    end
  end

  initial begin
    model_reset();
    reset = 1'b0;
    wait_clk(5);
    check8("rst_miso", {7'd0, MISO}, 8'd0);
    check8("rst_busy", {7'd0, busy}, 8'd0);
    check8("rst_wr_valid", {7'd0, wr_valid}, 8'd0);
    check8("rst_wr_addr", {2'd0, wr_addr}, 8'd0);
    check8("rst_wr_data", wr_data, 8'd0);
    reset = 1'b1;
    wait_clk(10);
    miso_quiet = 1'b1;

    // Single write then read back.
    tx_buf[0] = 8'h2D; tx_buf[1] = 8'h08; spi_frame(2, 0, -1, 48'h0);
    tx_buf[0] = 8'hAD; tx_buf[1] = 8'h00; spi_frame(2, 0, -1, 48'h0);
    check8("lit_rd_2d", rx_buf[1], 8'h08);

    // DEVID is read-only but a write to 0x00 still reports.
    tx_buf[0] = 8'h80; spi_frame(2, 0, -1, 48'h0);
    check8("lit_devid", rx_buf[1], 8'hE5);
    tx_buf[0] = 8'h00; tx_buf[1] = 8'h55; spi_frame(2, 0, -1, 48'h0);
    tx_buf[0] = 8'h80; tx_buf[1] = 8'h00; spi_frame(2, 0, -1, 48'h0);
    check8("lit_devid_after_wr", rx_buf[1], 8'hE5);

    // Idle sample load then burst read.
    sample_idle(48'h0123456789AB);
    lit = '{8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
    tx_buf[0] = 8'hF2;
    for (int i = 1; i < 7; i++) tx_buf[i] = 8'h00;
    spi_frame(7, 0, -1, 48'h0);
    for (int i = 0; i < 6; i++) check8($sformatf("lit_burst%0d", i), rx_buf[i+1], lit[i]);

    // Sample arriving mid-burst must not tear the read.
    spi_frame(7, 0, 2, 48'hFFFF_FFFF_FFFF);
    for (int i = 0; i < 6; i++) check8($sformatf("lit_notear%0d", i), rx_buf[i+1], lit[i]);
    spi_frame(7, 0, -1, 48'h0);
    for (int i = 0; i < 6; i++) check8($sformatf("lit_pending%0d", i), rx_buf[i+1], 8'hFF);

    // Auto-increment wraps 0x3F -> 0x00.
    tx_buf[0] = 8'h3F; tx_buf[1] = 8'h9C; spi_frame(2, 0, -1, 48'h0);
    tx_buf[0] = 8'hFF; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00; spi_frame(3, 0, -1, 48'h0);
    check8("lit_wrap0", rx_buf[1], 8'h9C);
    check8("lit_wrap1", rx_buf[2], 8'hE5);

    // MB=0 repeats one address; MB=1 increments.
    tx_buf[0] = 8'h10; tx_buf[1] = 8'h11; tx_buf[2] = 8'h22; spi_frame(3, 0, -1, 48'h0);
    tx_buf[0] = 8'h90; tx_buf[1] = 8'h00; spi_frame(2, 0, -1, 48'h0);
    check8("lit_mb0", rx_buf[1], 8'h22);
    tx_buf[0] = 8'h58; tx_buf[1] = 8'hA1; tx_buf[2] = 8'hB2; tx_buf[3] = 8'hC3;
    spi_frame(4, 0, -1, 48'h0);
    tx_buf[0] = 8'hD8; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00; tx_buf[3] = 8'h00;
    spi_frame(4, 0, -1, 48'h0);
    check8("lit_mb1", rx_buf[3], 8'hC3);

    // Partial data byte is discarded.
    tx_buf[0] = 8'h2D; tx_buf[1] = 8'hF0; spi_frame(1, 5, -1, 48'h0);
    tx_buf[0] = 8'hAD; tx_buf[1] = 8'h00; spi_frame(2, 0, -1, 48'h0);
    check8("lit_abort_keep", rx_buf[1], 8'h08);

    // Reset in the middle of a DEVID read.
    miso_quiet = 1'b0;
    CS = 1'b0;
    wait_clk(4);
    spi_bits(8'h80, 8, r);
    spi_bits(8'h00, 2, r);
    check8("pre_rst_miso", {7'd0, MISO}, 8'd1);
    check8("pre_rst_busy", {7'd0, busy}, 8'd1);
    reset = 1'b0;
    wait_clk(1);
    check8("midrst_miso", {7'd0, MISO}, 8'd0);
    check8("midrst_busy", {7'd0, busy}, 8'd0);
    model_reset();
    wait_clk(2);
    reset = 1'b1;
    wait_clk(4);
    CS = 1'b1;
    SCLK = 1'b1;
    wait_clk(8);
    miso_quiet = 1'b1;
    tx_buf[0] = 8'hF2; tx_buf[1] = 8'h00; spi_frame(2, 0, -1, 48'h0);
    check8("lit_regs_cleared", rx_buf[1], 8'h00);
    tx_buf[0] = 8'h2D; tx_buf[1] = 8'h08; spi_frame(2, 0, -1, 48'h0);
    tx_buf[0] = 8'hAD; tx_buf[1] = 8'h00; spi_frame(2, 0, -1, 48'h0);
    check8("lit_after_rst", rx_buf[1], 8'h08);

    wait_clk(4);
    check8("writes_outstanding", 8'(exp_q.size()), 8'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
